regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its posedge.
REQ-004 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port AValid  input  1  requester A write request.
REQ-006 SHALL have port AReady  output  1  requester A accepted this cycle.
REQ-007 SHALL have port AAddr  input  ADDR_W  requester A target register.
REQ-008 SHALL have port AData  input  DATA_W  requester A write data.
REQ-009 SHALL have ports BValid, BReady, BAddr and BData, identical to the A ports, for requester B.
REQ-010 SHALL have port ClearStart  input  1  one-cycle pulse that starts the register-clear sweep (REGWR_CLEAR_EN only).
REQ-011 SHALL have port Busy  output  1  high while a clear sweep runs.
REQ-012 SHALL have port RegWrite  output  1  register file write enable.
REQ-013 SHALL have port WriteRegister  output  ADDR_W  register file write address.
REQ-014 SHALL have port WriteData  output  DATA_W  register file write data.

Function
REQ-015 SHALL implement states IDLE and CLEAR.
REQ-016 In IDLE, SHALL complete a handshake when Valid and Ready are both high in the same cycle.
REQ-017 SHALL make Ready combinational from the Valid inputs and the round-robin pointer.
REQ-018 SHALL never assert AReady and BReady in the same cycle.
REQ-019 When only one requester is valid, SHALL grant that requester regardless of the pointer.
REQ-020 When both requesters are valid, SHALL grant the requester named by the pointer.
REQ-021 After each grant, SHALL set the pointer to the non-granted requester; reset value of the pointer is A.
REQ-022 An accepted request SHALL drive RegWrite=1, WriteRegister=Addr and WriteData=Data in the cycle after the handshake (latency 1, registered).
REQ-023 A handshake to address 0 SHALL be accepted with RegWrite held 0, because register 0 is read-only zero.
REQ-024 In cycles with no handshake and no clear write, SHALL hold RegWrite=0; WriteRegister and WriteData hold their last values.
REQ-025 When ClearStart=1 in IDLE, SHALL enter CLEAR on the next cycle; if ClearStart and a Valid coincide, clear wins and no handshake occurs that cycle.
REQ-026 In CLEAR, SHALL hold AReady=BReady=0 and Busy=1.
REQ-027 In CLEAR, SHALL write 0 to registers 1 through 2**ADDR_W-1, ascending, one per cycle (31 writes for ADDR_W=5).
REQ-028 After the final clear write, SHALL return to IDLE, with Busy falling in the cycle after that write.
REQ-029 SHALL ignore ClearStart while in CLEAR.
REQ-030 The clear address counter SHALL stop at 2**ADDR_W-1 and SHALL NOT wrap.

Reset
REQ-031 On Reset=1 at posedge Clk, SHALL set state=IDLE, pointer=A, RegWrite=0, WriteRegister=0, WriteData=0, Busy=0 and clear counter=1.
REQ-032 While Reset=1, SHALL hold AReady=BReady=0.
REQ-033 Reset during CLEAR SHALL abort the sweep immediately; remaining registers are not written.

Configuration
REQ-034 SHALL use macro REGWR_CLEAR_EN to select the clear feature.
REQ-035 With REGWR_CLEAR_EN defined, SHALL include the ClearStart port, the CLEAR state and the counter.
REQ-036 Without REGWR_CLEAR_EN, SHALL omit ClearStart, the CLEAR state and the counter, tie Busy to 0, and run arbitration only.

Structure
REQ-037 SHALL place the state encoding, DATA_W/ADDR_W defaults and requester-ID constants in shared package regfile_pkg.
REQ-038 SHALL implement the two-way round-robin grant and pointer in sub-module rr_arbiter2.

Verification
REQ-039 SHALL cover: A only, AAddr=2, AData=42 -> AReady same cycle; next cycle RegWrite=1, WriteRegister=2, WriteData=42.
REQ-040 SHALL cover: A and B both valid for 4 cycles after reset (A→3/15, B→4/7) -> grants A,B,A,B; each write appears 1 cycle after its handshake.
REQ-041 SHALL cover: B only, BAddr=0, BData=99 -> BReady=1; RegWrite stays 0.
REQ-042 SHALL cover: ClearStart pulse with AValid=1 -> AReady=0; Busy=1 for 31 cycles; writes of 0 to addresses 1..31; then A is granted.
REQ-043 SHALL cover: Reset asserted at the 10th clear write -> next cycle state IDLE, Busy=0, RegWrite=0; addresses 11..31 not written.
REQ-044 SHALL cover: build without REGWR_CLEAR_EN -> Busy constantly 0; scenario REQ-040 passes unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, FSM state encoding and requester IDs for the regfile write arbiter
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer names who wins a tie and flips to the loser after each grant
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    req_id_e ptr_q;

    // a lone requester always wins; on a tie the pointer decides
    always_comb begin
        gnt_a_o = en_i && req_a_i && (!req_b_i || ptr_q == REQ_A);
        gnt_b_o = en_i && req_b_i && (!req_a_i || ptr_q == REQ_B);
    end

    // hand priority to the requester that just lost
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ptr_q <= REQ_A;
        else if (gnt_a_o)
            ptr_q <= REQ_B;
        else if (gnt_b_o)
            ptr_q <= REQ_A;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges two write requesters onto one register-file write port; optional clear sweep under REGWR_CLEAR_EN
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AValid,
    output logic              AReady,
    input  logic [ADDR_W-1:0] AAddr,
    input  logic [DATA_W-1:0] AData,
    input  logic              BValid,
    output logic              BReady,
    input  logic [ADDR_W-1:0] BAddr,
    input  logic [DATA_W-1:0] BData,
`ifdef REGWR_CLEAR_EN
    input  logic              ClearStart,
`endif
    output logic              Busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    logic              grant_en;
    logic              hs_d;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              wr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    rr_arbiter2 u_arb (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .en_i    (grant_en),
        .req_a_i (AValid),
        .req_b_i (BValid),
        .gnt_a_o (AReady),
        .gnt_b_o (BReady)
    );

    // select the granted requester; writes to register 0 are swallowed because it reads as zero
    always_comb begin
        hs_d   = AReady || BReady;
        addr_d = BReady ? BAddr : AAddr;
        data_d = BReady ? BData : AData;
        wr_d   = hs_d && (addr_d != '0);
    end

    assign RegWrite      = wr_q;
    assign WriteRegister = waddr_q;
    assign WriteData     = wdata_q;

`ifdef REGWR_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    assign grant_en = !Reset && (state_q == ST_IDLE) && !ClearStart;
    assign Busy     = busy_q;

    // FSM: cnt_q is the register being zeroed this cycle; the sweep ends after the last register is written
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= ADDR_W'(1);
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= ADDR_W'(1);
                wr_q    <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + ADDR_W'(1);
                wr_q    <= 1'b1;
                waddr_q <= cnt_q + ADDR_W'(1);
                wdata_q <= '0;
            end
        end else if (ClearStart) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= ADDR_W'(1);
            wr_q    <= 1'b1;
            waddr_q <= ADDR_W'(1);
            wdata_q <= '0;
        end else begin
            wr_q <= wr_d;
            if (wr_d) begin
                waddr_q <= addr_d;
                wdata_q <= data_d;
            end
        end
    end
`else
    assign grant_en = !Reset;
    assign Busy     = 1'b0;

    // register the accepted write one cycle after its handshake
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wr_q <= wr_d;
            if (wr_d) begin
                waddr_q <= addr_d;
                wdata_q <= data_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, write latency, register-0 handling and (with REGWR_CLEAR_EN) the clear sweep
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        AValid = 1'b0;
    logic        AReady;
    logic [4:0]  AAddr = '0;
    logic [31:0] AData = '0;
    logic        BValid = 1'b0;
    logic        BReady;
    logic [4:0]  BAddr = '0;
    logic [31:0] BData = '0;
`ifdef REGWR_CLEAR_EN
    logic        ClearStart = 1'b0;
`endif
    logic        Busy;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .AValid        (AValid),
        .AReady        (AReady),
        .AAddr         (AAddr),
        .AData         (AData),
        .BValid        (BValid),
        .BReady        (BReady),
        .BAddr         (BAddr),
        .BData         (BData),
`ifdef REGWR_CLEAR_EN
        .ClearStart    (ClearStart),
`endif
        .Busy          (Busy),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    always #5 Clk = ~Clk;

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1; AValid = 1'b1; BValid = 1'b1;
        #1;
        checks++;
        if (AReady !== 1'b0 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: AReady=%b BReady=%b expected 0/0", AReady, BReady);
        end
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: RegWrite=%b WriteRegister=%0d WriteData=%0d Busy=%b expected 0/0/0/0",
                     RegWrite, WriteRegister, WriteData, Busy);
        end
        @(negedge Clk);
        Reset = 1'b0; AValid = 1'b0; BValid = 1'b0;
    endtask

    task automatic test_a_only();
        @(negedge Clk);
        AValid = 1'b1; AAddr = 5'd2; AData = 32'd42;
        #1;
        checks++;
        if (AReady !== 1'b1 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL a_only_ready: AReady=%b BReady=%b expected 1/0", AReady, BReady);
        end
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd2 || WriteData !== 32'd42 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL a_only_write: RegWrite=%b WriteRegister=%0d WriteData=%0d Busy=%b expected 1/2/42/0",
                     RegWrite, WriteRegister, WriteData, Busy);
        end
        @(negedge Clk);
        AValid = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd2 || WriteData !== 32'd42) begin
            errors++;
            $display("FAIL a_only_hold: RegWrite=%b WriteRegister=%0d WriteData=%0d expected 0/2/42",
                     RegWrite, WriteRegister, WriteData);
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        @(negedge Clk);
        AValid = 1'b1; AAddr = 5'd3; AData = 32'd15;
        BValid = 1'b1; BAddr = 5'd4; BData = 32'd7;
        for (int i = 0; i < 4; i++) begin
            logic exp_a;
            exp_a = (i % 2 == 0);
            #1;
            checks++;
            if (AReady !== exp_a || BReady !== !exp_a) begin
                errors++;
                $display("FAIL rr_grant%0d: AReady=%b BReady=%b expected %b/%b", i, AReady, BReady, exp_a, !exp_a);
            end
            @(posedge Clk); #1;
            checks++;
            if (RegWrite !== 1'b1 || WriteRegister !== (exp_a ? 5'd3 : 5'd4) ||
                WriteData !== (exp_a ? 32'd15 : 32'd7) || Busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_write%0d: RegWrite=%b WriteRegister=%0d WriteData=%0d Busy=%b expected 1/%0d/%0d/0",
                         i, RegWrite, WriteRegister, WriteData, Busy, exp_a ? 3 : 4, exp_a ? 15 : 7);
            end
            @(negedge Clk);
        end
        AValid = 1'b0; BValid = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd4 || WriteData !== 32'd7) begin
            errors++;
            $display("FAIL rr_idle: RegWrite=%b WriteRegister=%0d WriteData=%0d expected 0/4/7",
                     RegWrite, WriteRegister, WriteData);
        end
    endtask

    task automatic test_b_addr0();
        @(negedge Clk);
        BValid = 1'b1; BAddr = 5'd0; BData = 32'd99;
        #1;
        checks++;
        if (BReady !== 1'b1 || AReady !== 1'b0) begin
            errors++;
            $display("FAIL b0_ready: AReady=%b BReady=%b expected 0/1", AReady, BReady);
        end
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL b0_regwrite: RegWrite=%b expected 0", RegWrite);
        end
        @(negedge Clk);
        BValid = 1'b0;
    endtask

`ifdef REGWR_CLEAR_EN
    task automatic test_clear();
        @(negedge Clk);
        ClearStart = 1'b1; AValid = 1'b1; AAddr = 5'd5; AData = 32'd55;
        #1;
        checks++;
        if (AReady !== 1'b0 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL clr_start_ready: AReady=%b BReady=%b expected 0/0", AReady, BReady);
        end
        @(posedge Clk); #1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge Clk);
            ClearStart = (i == 5);
            #1;
            checks++;
            if (AReady !== 1'b0 || Busy !== 1'b1 || RegWrite !== 1'b1 ||
                WriteRegister !== 5'(i) || WriteData !== 32'd0) begin
                errors++;
                $display("FAIL clr_write%0d: AReady=%b Busy=%b RegWrite=%b WriteRegister=%0d WriteData=%0d expected 0/1/1/%0d/0",
                         i, AReady, Busy, RegWrite, WriteRegister, WriteData, i);
            end
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        ClearStart = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || RegWrite !== 1'b0 || AReady !== 1'b1 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL clr_done: Busy=%b RegWrite=%b AReady=%b BReady=%b expected 0/0/1/0",
                     Busy, RegWrite, AReady, BReady);
        end
        @(posedge Clk); #1;
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'd55) begin
            errors++;
            $display("FAIL clr_after_grant: RegWrite=%b WriteRegister=%0d WriteData=%0d expected 1/5/55",
                     RegWrite, WriteRegister, WriteData);
        end
        @(negedge Clk);
        AValid = 1'b0;
    endtask

    task automatic test_clear_reset();
        int writes;
        @(negedge Clk);
        ClearStart = 1'b1;
        @(posedge Clk); #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            ClearStart = 1'b0;
            #1;
            checks++;
            if (Busy !== 1'b1 || RegWrite !== 1'b1 || WriteRegister !== 5'(i)) begin
                errors++;
                $display("FAIL clrrst_write%0d: Busy=%b RegWrite=%b WriteRegister=%0d expected 1/1/%0d",
                         i, Busy, RegWrite, WriteRegister, i);
            end
            if (i < 10) begin
                @(posedge Clk); #1;
            end
        end
        Reset = 1'b1; AValid = 1'b1;
        #1;
        checks++;
        if (AReady !== 1'b0 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL clrrst_ready: AReady=%b BReady=%b expected 0/0", AReady, BReady);
        end
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0 || RegWrite !== 1'b0 || WriteRegister !== 5'd0) begin
            errors++;
            $display("FAIL clrrst_abort: Busy=%b RegWrite=%b WriteRegister=%0d expected 0/0/0",
                     Busy, RegWrite, WriteRegister);
        end
        @(negedge Clk);
        Reset = 1'b0; AValid = 1'b0;
        writes = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk); #1;
            if (RegWrite !== 1'b0 || Busy !== 1'b0) writes++;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL clrrst_no_more_writes: cycles with RegWrite or Busy=%0d expected 0", writes);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_a_only();
        test_round_robin();
        test_b_addr0();
`ifdef REGWR_CLEAR_EN
        test_clear();
        test_clear_reset();
`endif
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0 || AReady !== 1'b0 || BReady !== 1'b0) begin
            errors++;
            $display("FAIL final_idle: Busy=%b AReady=%b BReady=%b expected 0/0/0", Busy, AReady, BReady);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
